// File: rtl/dpram_rd_ctrl_pkg.sv
// Shared definitions for the DPRAM line read controller: FSM encoding, output
// FIFO depth and the layout of the tagged FIFO word {sof, eol, data}.
package dpram_rd_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    localparam int FIFO_DEPTH = 2;

    // Tag offsets above the pixel field: word = {sof, eol, data}
    localparam int TAG_EOL_OFS = 0;
    localparam int TAG_SOF_OFS = 1;
    localparam int TAG_BITS    = 2;

endpackage

// File: rtl/dpram_rd_ctrl_fifo.sv
// Two-entry valid/ready FIFO holding tagged pixel words between the RAM read
// stage and the downstream pixel interface.
module rd_out_fifo
    import dpram_rd_ctrl_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  logic             pop,
    output logic [WIDTH-1:0] head_word,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;

    assign pop_ok    = pop && (count != 2'd0);
    assign valid     = (count != 2'd0);
    assign head_word = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    // Storage is data only; consumers never look at it while count is zero
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

endmodule

// File: rtl/dpram_rd_ctrl.sv
// Read side of the line ping-pong DPRAM: detects finished lines, streams the
// page out with SOF/EOL tags. Define DPRAM_RD_DROP_CNT_EN for the drop counter.
module dpram_rd_ctrl
    import dpram_rd_ctrl_pkg::*;
#(
    parameter int A_WIDTH    = 9,
    parameter int D_WIDTH    = 10,
    parameter int C_LINE_LEN = 250,
    parameter int C_ROWS     = 250
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               DPRAM_RD_PAGE,
    input  logic               FRAME_TGL,
    output logic [A_WIDTH-1:0] DPRAM_RD_ADDR,
    output logic               DPRAM_EN,
    input  logic [D_WIDTH-1:0] DPRAM_DO,
    output logic [D_WIDTH-1:0] PIX_DATA,
    output logic               PIX_VALID,
    input  logic               PIX_READY,
    output logic               PIX_SOF,
    output logic               PIX_EOL,
    output logic [15:0]        ROW_COUNT,
    output logic               LINE_DROP,
    output logic [15:0]        DROP_COUNT
);

    localparam int               IDX_W    = A_WIDTH - 1;
    localparam int               WORD_W   = D_WIDTH + TAG_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_LINE_LEN - 1);
    localparam logic [15:0]      ROW_MAX  = 16'(C_ROWS - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
        return (v >= lim) ? lim : v + 16'd1;
    endfunction

    logic page_s1, page_s2, page_h;
    logic frame_s1, frame_s2, frame_h;
    logic page_edge, frame_edge;

    rd_state_t        state, state_nxt;
    logic             consume, issue, credit_ok;
    logic             pending, pend_page, rd_page;
    logic [IDX_W-1:0] idx;
    logic             line_sof, sof_arm, sof_eff;
    logic             drop_evt, line_drop;
    logic [1:0]       lines_open;
    logic             clr_pend;
    logic [15:0]      row_count;

    logic              vld_p0, sof_p0, eol_p0;
    logic [WORD_W-1:0] push_word, head_word;
    logic              fifo_valid, pop, eol_xfer;
    logic [1:0]        fifo_count;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            page_s1  <= 1'b0;
            page_s2  <= 1'b0;
            page_h   <= 1'b0;
            frame_s1 <= 1'b0;
            frame_s2 <= 1'b0;
            frame_h  <= 1'b0;
        end else begin
            page_s1  <= DPRAM_RD_PAGE;
            page_s2  <= page_s1;
            page_h   <= page_s2;
            frame_s1 <= FRAME_TGL;
            frame_s2 <= frame_s1;
            frame_h  <= frame_s2;
        end
    end

    assign page_edge  = page_s2 ^ page_h;
    assign frame_edge = frame_s2 ^ frame_h;
    assign sof_eff    = sof_arm | frame_edge;

    // A pop this cycle frees a slot before the issued word lands, so count it
    assign credit_ok = ({1'b0, fifo_count} + {2'b0, vld_p0}) < (3'd2 + {2'b0, pop});

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        issue     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    consume   = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                issue = credit_ok;
                if (issue && (idx == LAST_IDX)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign drop_evt = page_edge && pending && !consume;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending    <= 1'b0;
            pend_page  <= 1'b0;
            rd_page    <= 1'b0;
            idx        <= '0;
            line_sof   <= 1'b0;
            sof_arm    <= 1'b1;
            line_drop  <= 1'b0;
            lines_open <= 2'd0;
            clr_pend   <= 1'b0;
            row_count  <= 16'd0;
            vld_p0     <= 1'b0;
        end else begin
            line_drop <= drop_evt;
            if (page_edge) begin
                pending   <= 1'b1;
                pend_page <= page_s2;
            end else if (consume) begin
                pending <= 1'b0;
            end

            // Frame edge is applied before a coincident line start
            if (consume) begin
                rd_page  <= pend_page;
                idx      <= '0;
                line_sof <= sof_eff;
                sof_arm  <= 1'b0;
            end else begin
                if (issue) idx <= idx + 1'b1;
                if (frame_edge) sof_arm <= 1'b1;
            end

            lines_open <= lines_open + {1'b0, consume} - {1'b0, eol_xfer};

            if (eol_xfer) begin
                if (clr_pend || frame_edge) begin
                    row_count <= 16'd0;
                    clr_pend  <= 1'b0;
                end else begin
                    row_count <= sat_inc(row_count, ROW_MAX);
                end
            end else if (frame_edge) begin
                if (lines_open != 2'd0) clr_pend  <= 1'b1;
                else                    row_count <= 16'd0;
            end

            vld_p0 <= issue;
        end
    end

    // Stage p0: RAM access in flight, tags travel alongside
    always_ff @(posedge CLOCK) begin
        sof_p0 <= line_sof && (idx == '0);
        eol_p0 <= (idx == LAST_IDX);
    end

    always_comb begin
        push_word                         = '0;
        push_word[D_WIDTH-1:0]            = DPRAM_DO;
        push_word[D_WIDTH + TAG_SOF_OFS]  = sof_p0;
        push_word[D_WIDTH + TAG_EOL_OFS]  = eol_p0;
    end

    rd_out_fifo #(
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .push      (vld_p0),
        .push_word (push_word),
        .pop       (pop),
        .head_word (head_word),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign pop      = fifo_valid && PIX_READY;
    assign eol_xfer = pop && head_word[D_WIDTH + TAG_EOL_OFS];

    assign DPRAM_EN      = issue;
    assign DPRAM_RD_ADDR = issue ? {rd_page, idx} : '0;
    assign PIX_VALID     = fifo_valid;
    assign PIX_DATA      = fifo_valid ? head_word[D_WIDTH-1:0] : '0;
    assign PIX_SOF       = fifo_valid && head_word[D_WIDTH + TAG_SOF_OFS];
    assign PIX_EOL       = fifo_valid && head_word[D_WIDTH + TAG_EOL_OFS];
    assign ROW_COUNT     = row_count;
    assign LINE_DROP     = line_drop;

`ifdef DPRAM_RD_DROP_CNT_EN
    logic [15:0] drop_count;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)      drop_count <= 16'd0;
        else if (drop_evt) drop_count <= sat_inc(drop_count, 16'hFFFF);
    end

    assign DROP_COUNT = drop_count;
`else
    assign DROP_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Directed bench for dpram_rd_ctrl: line streaming, backpressure, overrun,
// frame/row tracking, coincident edges and reset in the middle of a line.
module tb_dpram_rd_ctrl;

    localparam int A_WIDTH    = 9;
    localparam int D_WIDTH    = 10;
    localparam int C_LINE_LEN = 250;
    localparam int C_ROWS     = 250;

`ifdef DPRAM_RD_DROP_CNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    logic               CLOCK = 1'b0;
    logic               RESET_N = 1'b0;
    logic               DPRAM_RD_PAGE = 1'b0;
    logic               FRAME_TGL = 1'b0;
    logic               PIX_READY = 1'b0;
    logic [D_WIDTH-1:0] DPRAM_DO = '0;
    logic [A_WIDTH-1:0] DPRAM_RD_ADDR;
    logic               DPRAM_EN;
    logic [D_WIDTH-1:0] PIX_DATA;
    logic               PIX_VALID;
    logic               PIX_SOF;
    logic               PIX_EOL;
    logic [15:0]        ROW_COUNT;
    logic               LINE_DROP;
    logic [15:0]        DROP_COUNT;

    int tests = 0;
    int failed = 0;
    int drop_pulses = 0;

    dpram_rd_ctrl #(
        .A_WIDTH   (A_WIDTH),
        .D_WIDTH   (D_WIDTH),
        .C_LINE_LEN(C_LINE_LEN),
        .C_ROWS    (C_ROWS)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .DPRAM_RD_PAGE(DPRAM_RD_PAGE),
        .FRAME_TGL    (FRAME_TGL),
        .DPRAM_RD_ADDR(DPRAM_RD_ADDR),
        .DPRAM_EN     (DPRAM_EN),
        .DPRAM_DO     (DPRAM_DO),
        .PIX_DATA     (PIX_DATA),
        .PIX_VALID    (PIX_VALID),
        .PIX_READY    (PIX_READY),
        .PIX_SOF      (PIX_SOF),
        .PIX_EOL      (PIX_EOL),
        .ROW_COUNT    (ROW_COUNT),
        .LINE_DROP    (LINE_DROP),
        .DROP_COUNT   (DROP_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    // Port A model: one-cycle read latency, contents derived from the address
    always @(posedge CLOCK) begin
        if (DPRAM_EN) DPRAM_DO <= {1'b0, DPRAM_RD_ADDR} ^ 10'h2A5;
    end

    always @(negedge CLOCK) begin
        if (LINE_DROP) drop_pulses = drop_pulses + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [D_WIDTH-1:0] pix(input logic page, input int n);
        logic [A_WIDTH-1:0] a;
        a = {page, 8'(n)};
        return {1'b0, a} ^ 10'h2A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic collect(input string tag, input logic page, input logic sof, input int row,
                           input bit bp, input int npix, output int cycles);
        int n;
        bit stalled;
        bit r;
        logic [D_WIDTH-1:0] held;
        n = 0; cycles = 0; stalled = 1'b0; r = 1'b1; held = '0;
        while (n < npix && cycles < 4 * C_LINE_LEN + 50) begin
            if (stalled) begin
                check({tag, " hold_valid"}, PIX_VALID, 1);
                check({tag, " hold_data"}, PIX_DATA, held);
            end
            r = bp ? ~r : 1'b1;
            PIX_READY = r;
            stalled = PIX_VALID && !r;
            held = PIX_DATA;
            if (PIX_VALID && r) begin
                check({tag, " data"}, PIX_DATA, pix(page, n));
                check({tag, " sof"}, PIX_SOF, (sof && n == 0));
                check({tag, " eol"}, PIX_EOL, (n == C_LINE_LEN - 1));
                check({tag, " row"}, ROW_COUNT, row);
                n++;
            end
            step();
            cycles++;
        end
        check({tag, " count"}, n, npix);
    endtask

    initial begin
        int cyc;
        int base;
        bit seen;

        // Reset state
        PIX_READY = 1'b1;
        repeat (3) step();
        check("rst valid", PIX_VALID, 0);
        check("rst en", DPRAM_EN, 0);
        check("rst addr", DPRAM_RD_ADDR, 0);
        check("rst data", PIX_DATA, 0);
        check("rst row", ROW_COUNT, 0);
        check("rst drop", LINE_DROP, 0);
        check("rst dropcnt", DROP_COUNT, 0);
        RESET_N = 1'b1;
        repeat (3) step();

        // Single line, full throughput, latency from the page edge
        DPRAM_RD_PAGE = 1'b1;
        repeat (5) step();
        check("lat before", PIX_VALID, 0);
        step();
        check("lat first", PIX_VALID, 1);
        collect("single", 1'b1, 1'b1, 0, 1'b0, C_LINE_LEN, cyc);
        check("single cycles", cyc, C_LINE_LEN);
        check("single row after", ROW_COUNT, 1);

        // Backpressure
        DPRAM_RD_PAGE = 1'b0;
        collect("bp", 1'b0, 1'b0, 1, 1'b1, C_LINE_LEN, cyc);
        check("bp row after", ROW_COUNT, 2);

        // Overrun: three edges while the first line is stalled
        PIX_READY = 1'b0;
        base = drop_pulses;
        DPRAM_RD_PAGE = 1'b1;
        repeat (5) step();
        DPRAM_RD_PAGE = 1'b0;
        repeat (5) step();
        DPRAM_RD_PAGE = 1'b1;
        repeat (6) step();
        check("ovr drop pulses", drop_pulses - base, 1);
        check("ovr dropcnt", DROP_COUNT, EXP_DROP);
        collect("ovr first", 1'b1, 1'b0, 2, 1'b0, C_LINE_LEN, cyc);
        collect("ovr third", 1'b1, 1'b0, 3, 1'b0, C_LINE_LEN, cyc);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (PIX_VALID) seen = 1'b1;
        end
        check("ovr no extra line", seen, 0);
        check("ovr drop total", drop_pulses - base, 1);
        check("ovr row after", ROW_COUNT, 4);

        // Frame edge, then three lines
        FRAME_TGL = ~FRAME_TGL;
        repeat (4) step();
        check("frm row clear", ROW_COUNT, 0);
        DPRAM_RD_PAGE = 1'b0;
        collect("frm l0", 1'b0, 1'b1, 0, 1'b0, C_LINE_LEN, cyc);
        DPRAM_RD_PAGE = 1'b1;
        collect("frm l1", 1'b1, 1'b0, 1, 1'b0, C_LINE_LEN, cyc);
        DPRAM_RD_PAGE = 1'b0;
        collect("frm l2", 1'b0, 1'b0, 2, 1'b0, C_LINE_LEN, cyc);
        check("frm row 3", ROW_COUNT, 3);
        FRAME_TGL = ~FRAME_TGL;
        repeat (4) step();
        check("frm2 row clear", ROW_COUNT, 0);
        DPRAM_RD_PAGE = 1'b1;
        collect("frm2 l0", 1'b1, 1'b1, 0, 1'b0, C_LINE_LEN, cyc);
        check("frm2 row after", ROW_COUNT, 1);

        // Coincident page and frame edges
        DPRAM_RD_PAGE = 1'b0;
        FRAME_TGL = ~FRAME_TGL;
        collect("coin", 1'b0, 1'b1, 0, 1'b0, C_LINE_LEN, cyc);
        check("coin row after", ROW_COUNT, 1);

        // Reset in the middle of a line
        DPRAM_RD_PAGE = 1'b1;
        collect("mid", 1'b1, 1'b0, 1, 1'b0, 100, cyc);
        RESET_N = 1'b0;
        #1;
        check("mrst valid", PIX_VALID, 0);
        check("mrst data", PIX_DATA, 0);
        check("mrst sof", PIX_SOF, 0);
        check("mrst eol", PIX_EOL, 0);
        check("mrst en", DPRAM_EN, 0);
        check("mrst addr", DPRAM_RD_ADDR, 0);
        check("mrst row", ROW_COUNT, 0);
        check("mrst drop", LINE_DROP, 0);
        check("mrst dropcnt", DROP_COUNT, 0);
        DPRAM_RD_PAGE = 1'b0;
        FRAME_TGL = 1'b0;
        repeat (2) step();
        RESET_N = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (PIX_VALID) seen = 1'b1;
        end
        check("mrst quiet", seen, 0);
        DPRAM_RD_PAGE = 1'b1;
        collect("after rst", 1'b1, 1'b1, 0, 1'b0, C_LINE_LEN, cyc);
        check("after rst row", ROW_COUNT, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
